// File: rtl/dut_req_arbiter_if.sv
// Handshake bundle between the stimulus requesters,
// the round-robin arbiter and the dut_top input channel.
interface dut_req_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);
  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic                    out_ready;
  logic [SW-1:0]           out_src;
  logic                    busy;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last,
    input  out_src, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last,
    output out_src, busy
  );
endinterface

// File: rtl/dut_req_arbiter.sv
// Round-robin arbiter: locks one requester per packet
// or per MAX_BEATS burst, then rotates priority.
module dut_req_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BEATS = 8
) (
  input logic              clk,
  input logic              rst_n,
  dut_req_arbiter_if.slave bus
);
  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] CAP = 8'(MAX_BEATS - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] grant;
  logic [SW-1:0] pick;
  logic [7:0]    beat_cnt;
  logic          busy_q;
  logic          any_req;
  logic          xfer;

  // Lowest offset from rr_ptr wins, so scan offsets downward.
  always_comb begin
    pick    = rr_ptr;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (bus.req_valid[idx]) begin
        pick    = SW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (state == LOCK) begin
      bus.req_ready[grant] = bus.out_ready;
      bus.out_valid = bus.req_valid[grant];
      bus.out_data  =
        bus.req_data[int'(grant)*DATA_W +: DATA_W];
      bus.out_last  =
        bus.req_last[grant] | (beat_cnt == CAP);
    end
  end

  assign xfer = bus.out_valid & bus.out_ready;
  assign bus.out_src = grant;
  assign bus.busy    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= pick;
            beat_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (xfer && bus.out_last) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= (grant == SW'(N_REQ - 1)) ?
                        '0 : grant + 1'b1;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dut_req_arbiter.sv
// Directed bench for dut_req_arbiter: a cycle table plus
// queue-driven requesters for the multi-cycle cases.
module tb_dut_req_arbiter;
  logic clk;
  logic rst_n;

  dut_req_arbiter_if #(.N_REQ(4), .DATA_W(16)) bus ();

  dut_req_arbiter #(
    .N_REQ(4), .DATA_W(16), .MAX_BEATS(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [63:0] d;
    logic [3:0]  l;
    logic        rdy;
    logic        ov;
    logic [15:0] od;
    logic        ol;
    logic [1:0]  src;
    logic        bsy;
    logic [3:0]  rr;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [1:0]  s;
    logic [15:0] d;
    logic        l;
  } obs_t;

  int errors = 0;
  int checks = 0;

  beat_t q [4][$];
  obs_t  got [$];
  obs_t  exp [$];
  logic [3:0] gap;
  logic [3:0] hs;
  logic       rdy;
  vec_t       tv [11];

  task automatic chk(string nm, logic [63:0] a,
                     logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = (q[i].size() > 0) && !gap[i];
      bus.req_valid[i] = v;
      bus.req_data[i*16 +: 16] = v ? q[i][0].d : 16'h0;
      bus.req_last[i] = v ? q[i][0].l : 1'b0;
    end
    bus.out_ready = rdy;
  endtask

  // Sample the handshake mid-cycle, while inputs are stable.
  task automatic half1();
    drive();
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    if (bus.out_valid && bus.out_ready)
      got.push_back('{bus.out_src, bus.out_data,
                      bus.out_last});
  endtask

  task automatic half2();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i]) void'(q[i].pop_front());
  endtask

  task automatic run_until(int n, int budget,
                           output int cyc);
    cyc = 0;
    while (got.size() < n && cyc < budget) begin
      half1();
      half2();
      cyc++;
    end
  endtask

  task automatic load(int r, int n, logic [15:0] base);
    for (int k = 0; k < n; k++)
      q[r].push_back('{base + 16'(k), k == n - 1});
  endtask

  task automatic expect_run(int r, int from, int to,
                            logic [15:0] base, int lastk);
    for (int k = from; k <= to; k++)
      exp.push_back('{2'(r), base + 16'(k),
                      (k == lastk) || (k == to)});
  endtask

  task automatic check_beats(string nm);
    chk({nm, ".count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size())
        chk($sformatf("%s.beat%0d", nm, i), 64'(got[i]),
            64'(exp[i]));
    got.delete();
    exp.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy   = 1'b1;
    gap   = '0;
    for (int i = 0; i < 4; i++) q[i].delete();
    got.delete();
    exp.delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    tv[0]  = '{4'b0100, 64'h0000_ff89_0000_0000, 4'b0000,
               1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 4'b0000};
    tv[1]  = '{4'b0100, 64'h0000_ff89_0000_0000, 4'b0000,
               1'b1, 1'b1, 16'hff89, 1'b0, 2'd2, 1'b1, 4'b0100};
    tv[2]  = '{4'b0100, 64'h0000_0089_0000_0000, 4'b0000,
               1'b1, 1'b1, 16'h0089, 1'b0, 2'd2, 1'b1, 4'b0100};
    tv[3]  = '{4'b0100, 64'h0000_1234_0000_0000, 4'b0100,
               1'b1, 1'b1, 16'h1234, 1'b1, 2'd2, 1'b1, 4'b0100};
    tv[4]  = '{4'b0000, 64'h0, 4'b0000,
               1'b1, 1'b0, 16'h0000, 1'b0, 2'd2, 1'b0, 4'b0000};
    tv[5]  = '{4'b1001, 64'haaaa_0000_0000_5555, 4'b1001,
               1'b1, 1'b0, 16'h0000, 1'b0, 2'd2, 1'b0, 4'b0000};
    tv[6]  = '{4'b1001, 64'haaaa_0000_0000_5555, 4'b1001,
               1'b1, 1'b1, 16'haaaa, 1'b1, 2'd3, 1'b1, 4'b1000};
    tv[7]  = '{4'b0000, 64'h0, 4'b0000,
               1'b1, 1'b0, 16'h0000, 1'b0, 2'd3, 1'b0, 4'b0000};
    tv[8]  = '{4'b1001, 64'haaaa_0000_0000_5555, 4'b1001,
               1'b1, 1'b0, 16'h0000, 1'b0, 2'd3, 1'b0, 4'b0000};
    tv[9]  = '{4'b1001, 64'haaaa_0000_0000_5555, 4'b1001,
               1'b1, 1'b1, 16'h5555, 1'b1, 2'd0, 1'b1, 4'b0001};
    tv[10] = '{4'b0000, 64'h0, 4'b0000,
               1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 4'b0000};

    rst_n = 1'b0;
    rdy   = 1'b0;
    gap   = '0;
    drive();
    #1;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.out_data", 64'(bus.out_data), 64'd0);
    chk("rst.out_last", 64'(bus.out_last), 64'd0);
    chk("rst.out_src", 64'(bus.out_src), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.req_ready", 64'(bus.req_ready), 64'd0);

    // Single packet from requester 2, then rr_ptr wrap 3 -> 0.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.req_valid = tv[i].v;
      bus.req_data  = tv[i].d;
      bus.req_last  = tv[i].l;
      bus.out_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("tab%0d.ov", i),
          64'(bus.out_valid), 64'(tv[i].ov));
      chk($sformatf("tab%0d.od", i),
          64'(bus.out_data), 64'(tv[i].od));
      chk($sformatf("tab%0d.ol", i),
          64'(bus.out_last), 64'(tv[i].ol));
      chk($sformatf("tab%0d.src", i),
          64'(bus.out_src), 64'(tv[i].src));
      chk($sformatf("tab%0d.busy", i),
          64'(bus.busy), 64'(tv[i].bsy));
      chk($sformatf("tab%0d.rdy", i),
          64'(bus.req_ready), 64'(tv[i].rr));
      @(posedge clk);
      #1;
    end

    // All four requesters valid: 0,1,2,3 in 12 cycles.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      load(r, 2, 16'(r * 16'h100));
      expect_run(r, 0, 1, 16'(r * 16'h100), 1);
    end
    run_until(8, 60, cyc);
    chk("all4.cycles", 64'(cyc), 64'd12);
    chk("all4.busy_after", 64'(bus.busy), 64'd0);
    check_beats("all4");

    // Burst cap splits requester 1's 20-beat packet.
    do_reset();
    load(1, 20, 16'h1000);
    load(3, 2, 16'h3000);
    expect_run(1, 0, 7, 16'h1000, 7);
    expect_run(3, 0, 1, 16'h3000, 1);
    expect_run(1, 8, 15, 16'h1000, 15);
    expect_run(1, 16, 19, 16'h1000, 19);
    run_until(22, 200, cyc);
    check_beats("cap");

    // out_ready pattern 1,0,0,1: cut must land on 8th handshake.
    do_reset();
    load(2, 10, 16'h4000);
    expect_run(2, 0, 7, 16'h4000, 7);
    expect_run(2, 8, 9, 16'h4000, 9);
    for (int c = 0; c < 200 && got.size() < 10; c++) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      half1();
      if (bus.busy)
        chk($sformatf("stall%0d.req_ready", c),
            64'(bus.req_ready), rdy ? 64'h4 : 64'h0);
      half2();
    end
    rdy = 1'b1;
    check_beats("stall");

    // Reset mid-grant to requester 3.
    do_reset();
    load(3, 4, 16'h3000);
    half1();
    half2();
    half1();
    half2();
    drive();
    #1;
    chk("midrst.pre_data", 64'(bus.out_data), 64'h3001);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst.out_data", 64'(bus.out_data), 64'd0);
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    chk("midrst.req_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst.out_src", 64'(bus.out_src), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q[3].delete();
    got.delete();
    q[0].push_back('{16'h0a0a, 1'b1});
    q[3].push_back('{16'h3a3a, 1'b1});
    drive();
    @(posedge clk);
    #1;
    exp.push_back('{2'd0, 16'h0a0a, 1'b1});
    exp.push_back('{2'd3, 16'h3a3a, 1'b1});
    run_until(2, 40, cyc);
    check_beats("midrst");

    // Requester 0 stalls 5 cycles; grant must hold.
    do_reset();
    load(0, 6, 16'h0600);
    load(2, 2, 16'h2600);
    expect_run(0, 0, 5, 16'h0600, 5);
    expect_run(2, 0, 1, 16'h2600, 1);
    for (int s = 1; s <= 60 && got.size() < 8; s++) begin
      gap[0] = (s >= 4) && (s <= 8);
      half1();
      if (gap[0]) begin
        chk($sformatf("gap%0d.ov", s),
            64'(bus.out_valid), 64'd0);
        chk($sformatf("gap%0d.busy", s),
            64'(bus.busy), 64'd1);
        chk($sformatf("gap%0d.src", s),
            64'(bus.out_src), 64'd0);
        chk($sformatf("gap%0d.rdy2", s),
            64'(bus.req_ready[2]), 64'd0);
      end
      half2();
    end
    gap = '0;
    check_beats("gap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
